// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the processor load/store path
// (cpu) and a DMA/loader engine (dma). Ownership is registered and passed
// round-robin; a requester may lock ownership for bursts, and a hold limit
// forces a hand-over once the waiting side has been held off long enough.
module dmem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             cpu_lock,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_rvalid,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic             dma_lock,
    input  logic [WIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic             dma_gnt,
    output logic [WIDTH-1:0] dma_rdata,
    output logic             dma_rvalid,

    output logic             MemWrite,
    output logic [WIDTH-1:0] DataAdr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData
);

    // Hold counter only needs to reach MAX_HOLD-1, where it saturates.
    localparam int                CW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]     HOLD_TOP = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    typedef enum logic {
        LAST_CPU = 1'b0,
        LAST_DMA = 1'b1
    } owner_t;

    state_t        state;
    state_t        state_nxt;
    owner_t        last_owner;
    logic [CW-1:0] hold_cnt;

    // A transfer happens only while the owner is actually requesting; since
    // state resets asynchronously, an asserted reset drops both grants at once.
    always_comb begin
        cpu_gnt = (state == OWN_CPU) && cpu_req;
        dma_gnt = (state == OWN_DMA) && dma_req;
    end

    // Steer the granted requester onto the memory port; quiet port otherwise.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        if (cpu_gnt) begin
            MemWrite  = cpu_we;
            DataAdr   = cpu_adr;
            WriteData = cpu_wdata;
        end else if (dma_gnt) begin
            MemWrite  = dma_we;
            DataAdr   = dma_adr;
            WriteData = dma_wdata;
        end
    end

    // Ownership decision: forced release at the hold limit beats lock,
    // unlocked contention alternates, otherwise keep or release the port.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu_req && dma_req)
                    state_nxt = (last_owner == LAST_DMA) ? OWN_CPU : OWN_DMA;
                else if (cpu_req)
                    state_nxt = OWN_CPU;
                else if (dma_req)
                    state_nxt = OWN_DMA;
                else
                    state_nxt = IDLE;
            end
            OWN_CPU: begin
                if (dma_req && ((hold_cnt == HOLD_TOP) || !(cpu_req && cpu_lock)))
                    state_nxt = OWN_DMA;
                else if (cpu_req)
                    state_nxt = OWN_CPU;
                else
                    state_nxt = IDLE;
            end
            OWN_DMA: begin
                if (cpu_req && ((hold_cnt == HOLD_TOP) || !(dma_req && dma_lock)))
                    state_nxt = OWN_CPU;
                else if (dma_req)
                    state_nxt = OWN_DMA;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state: owner, round-robin history and tenure length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= LAST_DMA;
            hold_cnt   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;

            if (cpu_gnt)
                last_owner <= LAST_CPU;
            else if (dma_gnt)
                last_owner <= LAST_DMA;

            if (state_nxt != state)
                hold_cnt <= '0;
            else if ((cpu_gnt || dma_gnt) && (hold_cnt != HOLD_TOP))
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Capture read data at the end of a read grant; rvalid marks the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            if (cpu_gnt && !cpu_we)
                cpu_rdata <= ReadData;
            if (dma_gnt && !dma_we)
                dma_rdata <= ReadData;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural arbiter model
// and a word-addressed data memory kept in the bench.
module tb_dmem_port_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req, cpu_we, cpu_lock;
    logic [WIDTH-1:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic             cpu_gnt, cpu_rvalid;
    logic             dma_req, dma_we, dma_lock;
    logic [WIDTH-1:0] dma_adr, dma_wdata, dma_rdata;
    logic             dma_gnt, dma_rvalid;
    logic             MemWrite;
    logic [WIDTH-1:0] DataAdr, WriteData, ReadData;

    dmem_port_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    // Data memory behind the port (written by the DUT's MemWrite) and the
    // model's own copy (written by the model's predicted transfers).
    logic [WIDTH-1:0] mem     [128];
    logic [WIDTH-1:0] ref_mem [128];
    assign ReadData = mem[DataAdr[8:2]];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model: owner 0=none 1=cpu 2=dma, last grantee, grants in tenure.
    int               m_owner, m_last, m_streak;
    logic             exp_cv, exp_dv;
    logic [WIDTH-1:0] exp_crd, exp_drd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_owner  = 0;
        m_last   = 2;
        m_streak = 0;
        exp_cv   = 1'b0;
        exp_dv   = 1'b0;
        exp_crd  = '0;
        exp_drd  = '0;
    endfunction

    function automatic void m_step();
        logic gc, gd, mine_req, mine_lock, other_req;
        int   nxt, other;
        gc  = (m_owner == 1) && cpu_req;
        gd  = (m_owner == 2) && dma_req;
        nxt = 0;
        if (m_owner == 0) begin
            if (cpu_req && dma_req) nxt = (m_last == 2) ? 1 : 2;
            else if (cpu_req)       nxt = 1;
            else if (dma_req)       nxt = 2;
        end else begin
            other     = 3 - m_owner;
            mine_req  = (m_owner == 1) ? cpu_req  : dma_req;
            mine_lock = (m_owner == 1) ? cpu_lock : dma_lock;
            other_req = (m_owner == 1) ? dma_req  : cpu_req;
            if (other_req && m_streak == MAX_HOLD - 1)     nxt = other;
            else if (other_req && !(mine_req && mine_lock)) nxt = other;
            else if (mine_req)                              nxt = m_owner;
        end
        exp_cv = gc && !cpu_we;
        exp_dv = gd && !dma_we;
        if (exp_cv) exp_crd = ref_mem[cpu_adr[8:2]];
        if (exp_dv) exp_drd = ref_mem[dma_adr[8:2]];
        if (gc && cpu_we) ref_mem[cpu_adr[8:2]] = cpu_wdata;
        if (gd && dma_we) ref_mem[dma_adr[8:2]] = dma_wdata;
        if (gc) m_last = 1;
        if (gd) m_last = 2;
        if (nxt != m_owner)  m_streak = 0;
        else if (gc || gd)   m_streak = (m_streak + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_streak + 1;
        m_owner = nxt;
    endfunction

    // Compare every DUT output with the model mid-cycle.
    task automatic sample();
        logic             gc, gd, ew;
        logic [WIDTH-1:0] ea, ed;
        @(negedge clk);
        gc = (m_owner == 1) && cpu_req;
        gd = (m_owner == 2) && dma_req;
        ew = 1'b0; ea = '0; ed = '0;
        if (gc) begin ew = cpu_we; ea = cpu_adr; ed = cpu_wdata; end
        else if (gd) begin ew = dma_we; ea = dma_adr; ed = dma_wdata; end
        check("cpu_gnt",    cpu_gnt,    gc);
        check("dma_gnt",    dma_gnt,    gd);
        check("MemWrite",   MemWrite,   ew);
        check("DataAdr",    DataAdr,    ea);
        check("WriteData",  WriteData,  ed);
        check("cpu_rvalid", cpu_rvalid, exp_cv);
        check("dma_rvalid", dma_rvalid, exp_dv);
        check("cpu_rdata",  cpu_rdata,  exp_crd);
        check("dma_rdata",  dma_rdata,  exp_drd);
    endtask

    // Clock edge: commit the memory write, step the model, then leave a
    // small gap before the caller drives new inputs.
    task automatic advance();
        @(posedge clk);
        if (MemWrite) mem[DataAdr[8:2]] = WriteData;
        if (!reset) m_reset();
        else        m_step();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_adr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_adr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             gc, gd, got, got_c, cp, dp;
        logic [7:0]       pat;
        int               ng, rem_c, rem_d, n_d, n_mw;
        logic [WIDTH-1:0] old_word;

        for (int i = 0; i < 128; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;

        // Reset state, with a cpu request already pending.
        idle_inputs();
        cpu_req = 1; cpu_adr = 32'h40;
        reset = 1'b0;
        m_reset();
        #2;
        check("rst_cpu_gnt",  cpu_gnt,  0);
        check("rst_dma_gnt",  dma_gnt,  0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_adr",      DataAdr,  0);
        check("rst_wdata",    WriteData, 0);
        check("rst_rvalid",   {cpu_rvalid, dma_rvalid}, 0);
        check("rst_rdata",    cpu_rdata | dma_rdata, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Single cpu read of 0x40.
        sample(); check("rd_c0_gnt", cpu_gnt, 0); advance();
        sample();
        check("rd_c1_gnt", cpu_gnt, 1);
        check("rd_c1_adr", DataAdr, 32'h40);
        check("rd_c1_we",  MemWrite, 0);
        advance();
        cpu_req = 0;
        sample();
        check("rd_c2_rvalid", cpu_rvalid, 1);
        check("rd_c2_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        advance();
        sample(); check("rd_c3_rvalid", cpu_rvalid, 0); advance();

        // Simultaneous first request after reset: unlocked alternation.
        idle_inputs();
        do_reset();
        cpu_req = 1; cpu_adr = 32'h0;
        dma_req = 1; dma_we = 1; dma_adr = 32'h80; dma_wdata = $urandom;
        rem_c = 4; rem_d = 4; pat = '0; ng = 0;
        for (int i = 0; i < 20 && ng < 8; i++) begin
            sample();
            gc = cpu_gnt; gd = dma_gnt;
            check("alt_one_gnt", gc & gd, 0);
            if (gc) begin pat = {pat[6:0], 1'b1}; ng++; end
            if (gd) begin pat = {pat[6:0], 1'b0}; ng++; end
            advance();
            if (gc) begin rem_c--; if (rem_c == 0) cpu_req = 0; else cpu_adr += 4; end
            if (gd) begin
                rem_d--;
                if (rem_d == 0) dma_req = 0;
                else begin dma_adr += 4; dma_wdata = $urandom; end
            end
        end
        check("alt_count",   ng,  8);
        check("alt_pattern", pat, 8'hAA);
        sample(); advance();

        // Locked dma burst against a waiting cpu: hold limit forces release.
        idle_inputs();
        do_reset();
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_adr = 32'h80; dma_wdata = $urandom;
        sample(); advance();
        cpu_req = 1; cpu_adr = 32'h40;
        n_d = 0; got_c = 0;
        for (int i = 0; i < 30 && !got_c; i++) begin
            sample();
            gc = cpu_gnt; gd = dma_gnt;
            if (gd) n_d++;
            if (gc) got_c = 1;
            advance();
            if (gd) begin dma_adr += 4; dma_wdata = $urandom; end
            if (gc) cpu_req = 0;
        end
        check("lock_burst_len", n_d, MAX_HOLD);
        check("lock_cpu_gnt",   got_c, 1);
        sample(); check("lock_dma_regain", dma_gnt, 1); advance();
        idle_inputs();
        sample(); advance();
        sample(); advance();

        // dma write of 0x12345678 to 0x100, then cpu read back.
        dma_req = 1; dma_we = 1; dma_adr = 32'h100; dma_wdata = 32'h1234_5678;
        n_mw = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (MemWrite) n_mw++;
            if (dma_gnt) begin
                got = 1;
                check("wr_memwrite", MemWrite, 1);
                check("wr_adr",      DataAdr, 32'h100);
            end
            advance();
            if (got) begin dma_req = 0; dma_we = 0; end
        end
        check("wr_granted", got, 1);
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h100;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (MemWrite) n_mw++;
            if (cpu_gnt) got = 1;
            advance();
            if (got) cpu_req = 0;
        end
        sample();
        check("wr_rb_rvalid", cpu_rvalid, 1);
        check("wr_rb_rdata",  cpu_rdata, 32'h1234_5678);
        check("wr_mw_cycles", n_mw, 1);
        advance();

        // Async reset during a dma write grant kills the write at once.
        idle_inputs();
        old_word = mem[96];
        dma_req = 1; dma_we = 1; dma_lock = 1; dma_adr = 32'h180; dma_wdata = 32'hA5A5_A5A5;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (dma_gnt) got = 1;
            else advance();
        end
        check("ar_gnt_seen", got, 1);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check("ar_memwrite", MemWrite, 0);
        check("ar_dma_gnt",  dma_gnt, 0);
        check("ar_adr",      DataAdr, 0);
        @(posedge clk); #1;
        check("ar_no_commit", mem[96], old_word);
        reset = 1'b1;
        dma_lock = 0; dma_we = 0; cpu_req = 1; cpu_adr = 32'h8;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (cpu_gnt || dma_gnt) begin
                got = 1;
                check("ar_cpu_first", {cpu_gnt, dma_gnt}, 2'b10);
            end
            advance();
        end
        check("ar_granted", got, 1);
        idle_inputs();
        sample(); advance();
        sample(); advance();

        // Owner drops its request: empty owned cycle, then idle.
        do_reset();
        cpu_req = 1; cpu_adr = 32'h10;
        sample(); check("drop_c0", cpu_gnt, 0); advance();
        sample(); check("drop_c1", cpu_gnt, 1); advance();
        cpu_req = 0;
        sample(); check("drop_nognt", {cpu_gnt, dma_gnt}, 0); advance();
        sample(); advance();
        dma_req = 1; dma_adr = 32'h20;
        sample(); check("drop_dma_wait", dma_gnt, 0); advance();
        sample(); check("drop_dma_gnt",  dma_gnt, 1); advance();
        dma_req = 0;
        sample(); check("drop_dma_rvalid", dma_rvalid, 1); advance();

        // Random traffic obeying the hold-until-grant protocol.
        idle_inputs();
        do_reset();
        cp = 0; dp = 0;
        for (int i = 0; i < 3000; i++) begin
            sample();
            gc = cpu_gnt; gd = dma_gnt;
            advance();
            if (gc) cp = 0;
            if (gd) dp = 0;
            if (!cp) begin
                if ($urandom_range(0, 3) != 0) begin
                    cp = 1; cpu_req = 1;
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_adr   = 32'($urandom_range(0, 127)) << 2;
                    cpu_wdata = $urandom;
                    cpu_lock  = ($urandom_range(0, 2) == 0);
                end else cpu_req = 0;
            end
            if (!dp) begin
                if ($urandom_range(0, 3) != 0) begin
                    dp = 1; dma_req = 1;
                    dma_we    = 1'($urandom_range(0, 1));
                    dma_adr   = 32'($urandom_range(0, 127)) << 2;
                    dma_wdata = $urandom;
                    dma_lock  = ($urandom_range(0, 1) == 0);
                end else dma_req = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
